// File: rtl/multfix_pipe.sv
// rtl/multfix_pipe.sv - handshaked fixed-point multiplier with rounding, saturation and overflow flag
// Arithmetic is resolved combinationally ahead of the first stage; later stages only carry results.
module multfix_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int CYCLES = 2,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WIDTH-1:0]     io_a,
    input  logic [WIDTH-1:0]     io_b,
    input  logic                 io_round,
    input  logic                 io_sat,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [2*WIDTH-1:0]   io_q_unsc,
    output logic [WIDTH-1:0]     io_q_sc,
    output logic                 io_ovf
);

    localparam int W2 = 2 * WIDTH;
    localparam logic SGN = (SIGNED != 0);
    localparam logic [W2:0] HALF = ((W2 + 1)'(1) << FRAC) >> 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CYCLES-1:0] vld;
    logic [W2-1:0]     unsc_r [CYCLES];
    logic [WIDTH-1:0]  sc_r   [CYCLES];
    logic              ovf_r  [CYCLES];
    logic              en;

    logic [W2-1:0]     a_ext, b_ext, prod;
    logic [W2:0]       r, s;
    logic signed [W2:0] r_s, s_s;
    logic              ovf;
    logic [WIDTH-1:0]  sc;

    assign en          = !vld[CYCLES-1] || io_out_ready;
    assign io_in_ready = en;

    // Sign-extended operands make the truncated 2W-bit product correct for both modes.
    always_comb begin
        a_ext = {{WIDTH{io_a[WIDTH-1] & SGN}}, io_a};
        b_ext = {{WIDTH{io_b[WIDTH-1] & SGN}}, io_b};
        prod  = a_ext * b_ext;
        r     = {prod[W2-1] & SGN, prod} + (io_round ? HALF : '0);
        r_s   = r;
        s_s   = r_s >>> FRAC;
        if (SGN) begin
            s   = s_s;
            ovf = !((&s[W2:WIDTH-1]) || !(|s[W2:WIDTH-1]));
        end else begin
            s   = r >> FRAC;
            ovf = |s[W2:WIDTH];
        end
        sc = s[WIDTH-1:0];
        if (ovf && io_sat) begin
            if (SGN) sc = s[W2] ? SMIN : SMAX;
            else     sc = '1;
        end
    end

    // Data moves only behind a valid bit, so outputs keep their last value across bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < CYCLES; i++) begin
                unsc_r[i] <= '0;
                sc_r[i]   <= '0;
                ovf_r[i]  <= 1'b0;
            end
        end else if (en) begin
            vld[0] <= io_in_valid;
            if (io_in_valid) begin
                unsc_r[0] <= prod;
                sc_r[0]   <= sc;
                ovf_r[0]  <= ovf;
            end
            for (int i = 1; i < CYCLES; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    unsc_r[i] <= unsc_r[i-1];
                    sc_r[i]   <= sc_r[i-1];
                    ovf_r[i]  <= ovf_r[i-1];
                end
            end
        end
    end

    assign io_out_valid = vld[CYCLES-1];
    assign io_q_unsc    = unsc_r[CYCLES-1];
    assign io_q_sc      = sc_r[CYCLES-1];
    assign io_ovf       = ovf_r[CYCLES-1];

endmodule

// File: tb/tb_multfix_pipe.sv
// tb/tb_multfix_pipe.sv - scoreboard bench for multfix_pipe across four parameter sets
// All instances share stimulus; each keeps its own expected-result queue.
module tb_multfix_pipe;

    typedef struct {
        logic [31:0] unsc;
        logic [15:0] sc;
        logic        ovf;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    function automatic int cyc_of(int g);
        return (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    endfunction

    function automatic int sgn_of(int g);
        return (g == 3) ? 0 : 1;
    endfunction

    logic        clk, reset, in_valid, out_ready, rnd, sat;
    logic [15:0] a, b;
    logic [3:0]  in_ready, out_valid, ovf;
    logic [31:0] q_unsc [4];
    logic [15:0] q_sc   [4];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   lat_chk = 0;
    exp_t sb [4][$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        multfix_pipe #(.WIDTH(16), .FRAC(8), .CYCLES(cyc_of(g)), .SIGNED(sgn_of(g))) u_dut (
            .clk(clk), .reset(reset),
            .io_in_valid(in_valid), .io_in_ready(in_ready[g]),
            .io_a(a), .io_b(b), .io_round(rnd), .io_sat(sat),
            .io_out_valid(out_valid[g]), .io_out_ready(out_ready),
            .io_q_unsc(q_unsc[g]), .io_q_sc(q_sc[g]), .io_ovf(ovf[g])
        );
    end

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference: integer product, optional +half, floor divide by 2^FRAC, range test.
    function automatic exp_t model(int sgn, logic [15:0] x, logic [15:0] y, logic rd, logic st);
        exp_t   e;
        longint xv, yv, p, s, lo, hi;
        xv = x; yv = y;
        if (sgn != 0 && x[15]) xv -= 65536;
        if (sgn != 0 && y[15]) yv -= 65536;
        p  = xv * yv;
        s  = (p + (rd ? 128 : 0)) >>> 8;
        lo = (sgn != 0) ? -32768 : 0;
        hi = (sgn != 0) ? 32767 : 65535;
        e.unsc = p[31:0];
        e.ovf  = (s < lo) || (s > hi);
        if (e.ovf && st) s = (s < lo) ? lo : hi;
        e.sc = s[15:0];
        e.cyc = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int g = 0; g < 4; g++) begin
            if (out_valid[g]) begin
                checks++;
                if (sb[g].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid dut%0d: out_valid=1 with nothing outstanding", g);
                end else begin
                    e = sb[g][0];
                    if (q_unsc[g] !== e.unsc || q_sc[g] !== e.sc || ovf[g] !== e.ovf) begin
                        errors++;
                        $display("FAIL data dut%0d: got unsc=%h sc=%h ovf=%b, want unsc=%h sc=%h ovf=%b",
                                 g, q_unsc[g], q_sc[g], ovf[g], e.unsc, e.sc, e.ovf);
                    end
                    if (e.chk_lat) begin
                        checks++;
                        if (cyc - e.cyc != cyc_of(g)) begin
                            errors++;
                            $display("FAIL latency dut%0d: got %0d, want %0d", g, cyc - e.cyc, cyc_of(g));
                        end
                    end
                    if (out_ready) void'(sb[g].pop_front());
                end
            end
            if (reset && in_valid && in_ready[g]) begin
                e = model(sgn_of(g), a, b, rnd, sat);
                e.cyc = cyc;
                e.chk_lat = lat_chk;
                sb[g].push_back(e);
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (out_valid[g] !== 1'b0 || q_unsc[g] !== 32'h0 || q_sc[g] !== 16'h0 || ovf[g] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d: valid=%b unsc=%h sc=%h ovf=%b, want all zero",
                         tag, g, out_valid[g], q_unsc[g], q_sc[g], ovf[g]);
            end
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic rd, input logic st);
        int   n = 0;
        logic acc;
        a = x; b = y; rnd = rd; sat = st; in_valid = 1;
        do begin
            @(negedge clk);
            acc = in_ready[0];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=0 for %0d cycles, want 1", n);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (sb[g].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: %0d results outstanding, want 0", g, sb[g].size());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        reset = 0; in_valid = 0; out_ready = 1; a = 0; b = 0; rnd = 0; sat = 0;
        #2;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1;

        // Directed vectors, back to back, exact latency checked.
        lat_chk = 1;
        send(16'h0180, 16'h0200, 0, 0);
        send(16'hFF00, 16'h0280, 0, 0);
        send(16'h0001, 16'h0080, 0, 0);
        send(16'h0001, 16'h0080, 1, 0);
        send(16'h7FFF, 16'h7FFF, 0, 1);
        send(16'h7FFF, 16'h7FFF, 0, 0);
        send(16'h8000, 16'h7FFF, 0, 1);
        send(16'hFFFF, 16'h0200, 0, 1);
        send(16'h8000, 16'h8000, 1, 1);
        lat_chk = 0;
        drain();

        // Backpressure: six pairs streamed while the consumer stalls for four cycles.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_ready: in_ready=%b, want 0", in_ready[0]);
                    end
                    @(posedge clk);
                end
                #1;
                out_ready = 1;
            end
        join
        drain();

        // Asynchronous reset between edges discards two in-flight pairs.
        lat_chk = 1;
        send(16'h1234, 16'h0567, 0, 0);
        send(16'h0F0F, 16'h7000, 1, 1);
        #2;
        reset = 0;
        #1;
        check_zero("reset_mid");
        reset = 1;
        for (int g = 0; g < 4; g++) sb[g].delete();
        send(16'h0180, 16'h0200, 0, 0);
        lat_chk = 0;
        drain();

        // Randomized traffic with random consumer stalls.
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
